// File: rtl/vec_alu_pkg.sv
// Shared types and constants for the vector ALU issue logic.
package vec_alu_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Low bit position of a lane inside a packed vector.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vec_mul_sequencer_mult.sv
// Combinational n-bit signed multiplier: wrapped product plus signed-overflow flag.
module vec_mul_sequencer_mult #(
  parameter int n = 8
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  output logic [n-1:0] o_p,
  output logic         o_ovf,
  output logic         o_carry
);

  logic signed [2*n-1:0] w_a_ext;
  logic signed [2*n-1:0] w_b_ext;
  logic signed [2*n-1:0] w_full;

  assign w_a_ext = {{n{i_a[n-1]}}, i_a};
  assign w_b_ext = {{n{i_b[n-1]}}, i_b};
  assign w_full  = w_a_ext * w_b_ext;

  assign o_p     = w_full[n-1:0];
  // Representable only when the top n+1 bits are a pure sign extension.
  assign o_ovf   = (w_full[2*n-1:n-1] != {(n+1){1'b0}}) &&
                   (w_full[2*n-1:n-1] != {(n+1){1'b1}});
  assign o_carry = 1'b0;

endmodule

// File: rtl/vec_mul_sequencer.sv
// Streams one lane per cycle of a vector operand pair through a single shared
// signed multiplier and presents the collected result with a valid/ready handshake.
module vec_mul_sequencer
  import vec_alu_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LANES = DEF_LANES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] vec_a,
  input  logic [LANES*N-1:0] vec_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] vec_out,
  output logic [LANES-1:0]   ovf_mask,
  output logic               ovf_any,
  output logic               carry,
  output logic               busy
);

  localparam int               IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [LANES*N-1:0] r_op_a;
  logic [LANES*N-1:0] r_op_b;
  logic [LANES*N-1:0] r_vec_out;
  logic [LANES-1:0]   r_ovf_mask;
  logic [LANES-1:0]   w_lane_sel;
  logic [N-1:0]       w_mul_a;
  logic [N-1:0]       w_mul_b;
  logic [N-1:0]       w_mul_p;
  logic               w_mul_ovf;
  logic               w_mul_carry_unused;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_sel
      assign w_lane_sel[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    w_mul_a = r_op_a[N-1:0];
    w_mul_b = r_op_b[N-1:0];
    for (int i = 1; i < LANES; i++) begin
      if (w_lane_sel[i]) begin
        w_mul_a = r_op_a[lane_lo(i, N) +: N];
        w_mul_b = r_op_b[lane_lo(i, N) +: N];
      end
    end
  end

  vec_mul_sequencer_mult #(
    .n (N)
  ) u_mult (
    .i_a     (w_mul_a),
    .i_b     (w_mul_b),
    .o_p     (w_mul_p),
    .o_ovf   (w_mul_ovf),
    .o_carry (w_mul_carry_unused)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (r_idx == LAST_IDX) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_vec_out  <= '0;
      r_ovf_mask <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op_a     <= vec_a;
            r_op_b     <= vec_b;
            r_vec_out  <= '0;
            r_ovf_mask <= '0;
            r_idx      <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < LANES; i++) begin
            if (w_lane_sel[i]) begin
              r_vec_out[lane_lo(i, N) +: N] <= w_mul_p;
              r_ovf_mask[i]                 <= w_mul_ovf;
            end
          end
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // All handshake outputs come straight from registered state.
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign vec_out   = r_vec_out;
  assign ovf_mask  = r_ovf_mask;
  assign ovf_any   = |r_ovf_mask;
  assign carry     = 1'b0;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Scoreboard bench for vec_mul_sequencer (LANES=4 main instance, LANES=1 second instance).
module tb_vec_mul_sequencer;

  localparam int N     = 8;
  localparam int LANES = 4;
  localparam int W     = N * LANES;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     vec_a;
  logic [W-1:0]     vec_b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     vec_out;
  logic [LANES-1:0] ovf_mask;
  logic             ovf_any;
  logic             carry;
  logic             busy;

  logic             in_valid1;
  logic             in_ready1;
  logic [N-1:0]     vec_a1;
  logic [N-1:0]     vec_b1;
  logic             out_valid1;
  logic             out_ready1;
  logic [N-1:0]     vec_out1;
  logic [0:0]       ovf_mask1;
  logic             ovf_any1;
  logic             carry1;
  logic             busy1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accept_cyc = 0;

  typedef struct {
    logic [W-1:0]     v;
    logic [LANES-1:0] m;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_mul_sequencer #(.N(N), .LANES(LANES)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .vec_a(vec_a), .vec_b(vec_b), .out_valid(out_valid), .out_ready(out_ready),
    .vec_out(vec_out), .ovf_mask(ovf_mask), .ovf_any(ovf_any), .carry(carry), .busy(busy)
  );

  vec_mul_sequencer #(.N(N), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .vec_a(vec_a1), .vec_b(vec_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .vec_out(vec_out1), .ovf_mask(ovf_mask1), .ovf_any(ovf_any1), .carry(carry1), .busy(busy1)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   p;
    for (int i = 0; i < LANES; i++) begin
      p = int'($signed(a[i*N +: N])) * int'($signed(b[i*N +: N]));
      e.v[i*N +: N] = p[N-1:0];
      e.m[i] = (p > (2**(N-1)) - 1) || (p < -(2**(N-1)));
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    @(negedge clk);
    vec_a    = a;
    vec_b    = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
      accept_cyc = cyc;
      sb.push_back(model(a, b));
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin
        ok  = 1'b1;
        lat = cyc - accept_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; vec_a = '0; vec_b = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; vec_a1 = '0; vec_b1 = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (vec_out !== '0) begin failures++; $display("FAIL reset_vec_out: got %h want 0", vec_out); end
    checks++; if (ovf_mask !== '0) begin failures++; $display("FAIL reset_ovf_mask: got %b want 0", ovf_mask); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry: got %b want 0", carry); end
    $display("reset: in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid);
    rst = 1'b0;
  endtask

  task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    bit   ok;
    int   lat;
    exp_t e;
    do_accept(a, b, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_accept: got no accept want accept", name); return; end
    wait_out(lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_out_valid: got timeout want out_valid", name); return; end
    e = sb.pop_front();
    checks++; if (lat !== LANES) begin failures++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LANES); end
    checks++; if (vec_out !== e.v) begin failures++; $display("FAIL %s_vec_out: got %h want %h", name, vec_out, e.v); end
    checks++; if (ovf_mask !== e.m) begin failures++; $display("FAIL %s_ovf_mask: got %b want %b", name, ovf_mask, e.m); end
    checks++; if (ovf_any !== (|e.m)) begin failures++; $display("FAIL %s_ovf_any: got %b want %b", name, ovf_any, |e.m); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL %s_carry: got %b want 0", name, carry); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL %s_done_flags: got in_ready=%b busy=%b want 0/1", name, in_ready, busy); end
    $display("%s: a=%h b=%h out=%h ovf=%b lat=%0d", name, a, b, vec_out, ovf_mask, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL %s_release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready); end
  endtask

  task automatic test_stall();
    bit   ok;
    int   lat;
    exp_t e;
    do_accept(pack4(-5, 20, 100, -1), pack4(7, -9, 2, -1), ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_accept: got no accept want accept"); return; end
    wait_out(lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_out_valid: got timeout want out_valid"); return; end
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      vec_a    = W'($urandom);
      vec_b    = W'($urandom);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_c%0d: got %b want 1", c, out_valid); end
      checks++; if (vec_out !== e.v) begin failures++; $display("FAIL stall_vec_out_c%0d: got %h want %h", c, vec_out, e.v); end
      checks++; if (ovf_mask !== e.m) begin failures++; $display("FAIL stall_ovf_c%0d: got %b want %b", c, ovf_mask, e.m); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready_c%0d: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_no_overlap: got in_ready=%b want 0", in_ready); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    $display("stall: out=%h ovf=%b held 5 cycles", e.v, e.m);
  endtask

  task automatic test_abort();
    bit ok;
    int seen;
    exp_t e;
    do_accept(pack4(5, 6, 7, 8), pack4(3, 3, 3, 3), ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_accept: got no accept want accept"); return; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e = sb.pop_back();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle: got in_ready=%b busy=%b want 1/0", in_ready, busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    checks++; if (vec_out !== '0 || ovf_mask !== '0) begin failures++; $display("FAIL abort_cleared: got %h/%b want 0/0", vec_out, ovf_mask); end
    seen = 0;
    for (int k = 0; k < LANES + 3; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_result: got %0d valid cycles want 0 (dropped %h)", seen, e.v); end
    $display("abort: reset at idx=2, pending result discarded");
    test_vector("after_abort", pack4(-100, 50, 2, -3), pack4(2, 3, -64, -3));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    int           acc [3];
    int           got;
    bit           drv_ok;
    exp_t         e;
    for (int v = 0; v < 3; v++) begin
      va[v] = W'($urandom);
      vb[v] = W'($urandom);
    end
    got    = 0;
    drv_ok = 1'b1;
    out_ready = 1'b1;
    fork
      begin
        @(negedge clk);
        in_valid = 1'b1;
        for (int v = 0; v < 3; v++) begin
          bit found;
          vec_a = va[v];
          vec_b = vb[v];
          found = 1'b0;
          for (int k = 0; k < 50; k++) begin
            if (in_ready) begin found = 1'b1; break; end
            @(negedge clk);
          end
          if (!found) begin drv_ok = 1'b0; break; end
          @(negedge clk);
          acc[v] = cyc;
          sb.push_back(model(va[v], vb[v]));
          $display("b2b: accept %0d at cycle %0d a=%h b=%h", v, acc[v], va[v], vb[v]);
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 100 && got < 3; k++) begin
          @(negedge clk);
          if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
              failures++; $display("FAIL b2b_unexpected: got out=%h want no result", vec_out);
            end else begin
              e = sb.pop_front();
              if (vec_out !== e.v || ovf_mask !== e.m) begin
                failures++; $display("FAIL b2b_result_%0d: got %h/%b want %h/%b", got, vec_out, ovf_mask, e.v, e.m);
              end
            end
            $display("b2b: result %0d out=%h ovf=%b", got, vec_out, ovf_mask);
            got++;
          end
        end
      end
    join
    out_ready = 1'b0;
    checks++; if (!drv_ok) begin failures++; $display("FAIL b2b_accept: got timeout want accept"); end
    checks++; if (got !== 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", got); end
    if (drv_ok) begin
      checks++; if (acc[1] - acc[0] !== LANES + 2) begin failures++; $display("FAIL b2b_spacing01: got %0d want %0d", acc[1] - acc[0], LANES + 2); end
      checks++; if (acc[2] - acc[1] !== LANES + 2) begin failures++; $display("FAIL b2b_spacing12: got %0d want %0d", acc[2] - acc[1], LANES + 2); end
    end
    sb.delete();
  endtask

  task automatic test_lanes1();
    int a_tab [2] = '{-7, 100};
    int b_tab [2] = '{9, 3};
    for (int t = 0; t < 2; t++) begin
      int   p;
      int   acc;
      int   lat;
      bit   found;
      logic [7:0] a8;
      logic [7:0] b8;
      logic [N-1:0] exp_v;
      logic exp_m;
      a8 = a_tab[t][7:0];
      b8 = b_tab[t][7:0];
      p  = a_tab[t] * b_tab[t];
      exp_v = p[N-1:0];
      exp_m = (p > 127) || (p < -128);
      @(negedge clk);
      vec_a1 = a8; vec_b1 = b8; in_valid1 = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
        if (in_ready1) begin found = 1'b1; break; end
        @(negedge clk);
      end
      checks++; if (!found) begin failures++; $display("FAIL l1_accept_%0d: got no accept want accept", t); in_valid1 = 1'b0; continue; end
      @(negedge clk);
      acc = cyc;
      in_valid1 = 1'b0;
      found = 1'b0;
      lat = -1;
      for (int k = 0; k < 50; k++) begin
        if (out_valid1) begin found = 1'b1; lat = cyc - acc; break; end
        @(negedge clk);
      end
      checks++; if (!found) begin failures++; $display("FAIL l1_out_valid_%0d: got timeout want out_valid", t); continue; end
      checks++; if (lat !== 1) begin failures++; $display("FAIL l1_latency_%0d: got %0d want 1", t, lat); end
      checks++; if (vec_out1 !== exp_v) begin failures++; $display("FAIL l1_vec_out_%0d: got %h want %h", t, vec_out1, exp_v); end
      checks++; if (ovf_mask1 !== exp_m || ovf_any1 !== exp_m) begin failures++; $display("FAIL l1_ovf_%0d: got %b/%b want %b", t, ovf_mask1, ovf_any1, exp_m); end
      checks++; if (carry1 !== 1'b0 || busy1 !== 1'b1) begin failures++; $display("FAIL l1_flags_%0d: got carry=%b busy=%b want 0/1", t, carry1, busy1); end
      $display("lanes1: a=%0d b=%0d out=%h ovf=%b lat=%0d", a_tab[t], b_tab[t], vec_out1, ovf_mask1, lat);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL l1_release_%0d: got out_valid=%b in_ready=%b want 0/1", t, out_valid1, in_ready1); end
    end
  endtask

  initial begin
    test_reset();
    test_vector("basic", pack4(3, -2, 10, 0), pack4(4, 5, -3, 127));
    test_vector("overflow", pack4(-128, 16, 127, -128), pack4(-128, 16, -1, 1));
    test_stall();
    test_abort();
    test_back_to_back();
    test_lanes1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
